// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: register index width,
// the hard-wired zero register and the default register count.
package mips_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
    localparam int NREGS_DEFAULT = 32;

    // True when an index names a register that physically exists.
    function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx, input int nregs);
        return (int'(idx) < nregs);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Raw register storage: one synchronous write port, two asynchronous
// read ports, synchronous active-low clear. Knows nothing about $0
// or bypassing; the caller owns those rules.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int size  = 31,
    parameter int nregs = NREGS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [size:0]        wd,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [size:0]        rd1,
    output logic [size:0]        rd2
);

    logic [size:0]    mem_reg [nregs];
    logic [nregs-1:0] wsel;

    // One-hot write decode, one select line per storage entry.
    genvar gi;
    generate
        for (gi = 0; gi < nregs; gi++) begin : g_wsel
            assign wsel[gi] = we && (wa == REG_IDX_W'(gi));
        end
    endgenerate

    // Clear everything on reset, otherwise commit into the selected entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < nregs; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < nregs; i++) begin
                if (wsel[i]) begin
                    mem_reg[i] <= wd;
                end
            end
        end
    end

    // Indices beyond the populated range read as zero.
    assign rd1 = idx_in_range(ra1, nregs) ? mem_reg[ra1] : '0;
    assign rd2 = idx_in_range(ra2, nregs) ? mem_reg[ra2] : '0;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file. Selects the
// write-back result, commits it, serves two decode read ports with a
// same-cycle bypass of the W-stage write, and counts committed writes.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int size  = 31,
    parameter int nregs = NREGS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegW,
    input  logic [size:0]        ReadDataW,
    input  logic [size:0]        ALUOutW,
    input  logic [REG_IDX_W-1:0] WriteRegW,
    input  logic [REG_IDX_W-1:0] A1,
    input  logic [REG_IDX_W-1:0] A2,
    output logic [size:0]        RD1,
    output logic [size:0]        RD2,
    output logic [size:0]        ResultW,
    output logic [31:0]          WriteCountW
);

    logic                          we;
    logic [size:0]                 rf_rd1;
    logic [size:0]                 rf_rd2;
    logic [31:0]                   count_reg;
    logic [31:0]                   count_next;
    logic [1:0][REG_IDX_W-1:0]     port_addr;
    logic [1:0][size:0]            port_raw;
    logic [1:0][size:0]            port_rd;

    // Result mux is purely combinational and ignores reset.
    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    // A commit needs reset released, a write request, a non-zero
    // destination and a destination that actually exists.
    assign we = rst_n & RegWriteW & (WriteRegW != ZERO_REG) & idx_in_range(WriteRegW, nregs);

    regfile_2r1w #(
        .size  (size),
        .nregs (nregs)
    ) u_storage (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (WriteRegW),
        .wd    (ResultW),
        .ra1   (A1),
        .ra2   (A2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2)
    );

    assign port_addr = {A2, A1};
    assign port_raw  = {rf_rd2, rf_rd1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [size:0] sel_rd;

            // Read priority: reset/$0 force zero, then the W-stage bypass, then storage.
            always_comb begin
                sel_rd = '0;
                if (!rst_n || port_addr[gi] == ZERO_REG) begin
                    sel_rd = '0;
                end else if (we && port_addr[gi] == WriteRegW) begin
                    sel_rd = ResultW;
                end else begin
                    sel_rd = port_raw[gi];
                end
            end

            assign port_rd[gi] = sel_rd;
        end
    endgenerate

    assign RD1 = port_rd[0];
    assign RD2 = port_rd[1];

    // Commit counter wraps naturally at 2^32.
    assign count_next = count_reg + 32'd1;

    // Count only writes that actually land in the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (we) begin
            count_reg <= count_next;
        end
    end

    assign WriteCountW = count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver computes expected outputs
// from a behavioural register-file model and queues them; a monitor
// compares them against the DUT outputs each cycle.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] WriteCountW;

    always #5 clk = ~clk;

    wb_regfile #(
        .size  (31),
        .nregs (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWriteW   (RegWriteW),
        .MemtoRegW   (MemtoRegW),
        .ReadDataW   (ReadDataW),
        .ALUOutW     (ALUOutW),
        .WriteRegW   (WriteRegW),
        .A1          (A1),
        .A2          (A2),
        .RD1         (RD1),
        .RD2         (RD2),
        .ResultW     (ResultW),
        .WriteCountW (WriteCountW)
    );

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic [31:0] cnt;
        bit          chk_cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;

    // Reference model: architectural contents and commit count.
    logic [31:0] rf_m [32];
    logic [31:0] cnt_m = '0;
    bit          cnt_known = 1'b0;

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic rst,
                                               input bit we, input logic [4:0] wr,
                                               input logic [31:0] res);
        if (!rst || a == 5'd0) return 32'd0;
        if (we && a == wr) return res;
        return rf_m[a];
    endfunction

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h, required %h", name, field, act, exp);
        end
    endtask

    // One W-stage cycle: drive at negedge, queue the expectation, then
    // advance the model to the state after the following rising edge.
    task automatic xact(input string name, input logic rst, input logic rw, input logic m2r,
                        input logic [31:0] rdat, input logic [31:0] alu,
                        input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
        exp_t        e;
        logic [31:0] res;
        bit          we;
        @(negedge clk);
        rst_n = rst; RegWriteW = rw; MemtoRegW = m2r;
        ReadDataW = rdat; ALUOutW = alu; WriteRegW = wr; A1 = a1; A2 = a2;
        res = m2r ? rdat : alu;
        we  = rst && rw && (wr != 5'd0);
        e.name    = name;
        e.res     = res;
        e.rd1     = model_read(a1, rst, we, wr, res);
        e.rd2     = model_read(a2, rst, we, wr, res);
        e.cnt     = cnt_m;
        e.chk_cnt = cnt_known;
        sb.push_back(e);
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_m[i] = '0;
            cnt_m     = '0;
            cnt_known = 1'b1;
        end else if (we) begin
            rf_m[wr] = res;
            cnt_m    = cnt_m + 32'd1;
        end
    endtask

    // Preload the counter close to its wrap point through an idle cycle.
    task automatic force_count(input logic [31:0] val);
        @(negedge clk);
        rst_n = 1'b1; RegWriteW = 1'b0;
        force dut.count_reg = val;
        @(posedge clk);
        #1;
        release dut.count_reg;
        cnt_m = val;
    endtask

    // Monitor: compare the oldest expectation against the settled outputs.
    always begin
        @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            $display("[TB] %s rd1=%h rd2=%h res=%h cnt=%h", mon_e.name, RD1, RD2, ResultW, WriteCountW);
            check(mon_e.name, "RD1", RD1, mon_e.rd1);
            check(mon_e.name, "RD2", RD2, mon_e.rd2);
            check(mon_e.name, "ResultW", ResultW, mon_e.res);
            if (mon_e.chk_cnt) check(mon_e.name, "WriteCountW", WriteCountW, mon_e.cnt);
        end
    end

    initial begin
        logic [4:0]  wr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  prev_wr;
        logic        rst;
        logic        rw;
        int          pick;

        rst_n = 1'b0; RegWriteW = 1'b0; MemtoRegW = 1'b0;
        ReadDataW = '0; ALUOutW = '0; WriteRegW = '0; A1 = '0; A2 = '0;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;

        // Power-up reset and directed reset-clear scenario.
        xact("por",         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        xact("idle0",       1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        xact("wr_r5",       1'b1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0);
        xact("rd_r5",       1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        xact("rst_wr_r7",   1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 5'd7, 5'd5, 5'd7);
        xact("after_rst",   1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);

        // Result mux and commit.
        xact("mem_wr_r3",   1'b1, 1'b1, 1'b1, 32'h1234, 32'h9999, 5'd3, 5'd1, 5'd3);
        xact("rd_r3",       1'b1, 1'b0, 1'b1, 32'h1234, 32'h9999, 5'd0, 5'd1, 5'd3);
        xact("alu_wr_r4",   1'b1, 1'b1, 1'b0, 32'h1234, 32'h9999, 5'd4, 5'd3, 5'd0);
        xact("rd_r4",       1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd3);

        // $0 protection.
        xact("wr_r0",       1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        xact("rd_r0",       1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Same-cycle bypass on both ports.
        xact("wr_r8_11",    1'b1, 1'b1, 1'b0, 32'h0, 32'h11, 5'd8, 5'd0, 5'd0);
        xact("nowr_r8_22",  1'b1, 1'b0, 1'b0, 32'h0, 32'h22, 5'd8, 5'd8, 5'd8);
        xact("byp_r8_22",   1'b1, 1'b1, 1'b0, 32'h0, 32'h22, 5'd8, 5'd8, 5'd8);
        xact("rd_r8",       1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);

        // Counter wrap.
        force_count(32'hFFFFFFFE);
        xact("wrap_w1",     1'b1, 1'b1, 1'b0, 32'h0, 32'hA1, 5'd9, 5'd9, 5'd8);
        xact("wrap_w2",     1'b1, 1'b1, 1'b1, 32'hB2, 32'h0, 5'd10, 5'd9, 5'd10);
        xact("wrap_nowr",   1'b1, 1'b0, 1'b0, 32'h0, 32'hC3, 5'd11, 5'd10, 5'd11);
        xact("wrap_chk",    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd9);

        // Randomised back-to-back traffic with read-after-write on the next cycle.
        prev_wr = 5'd1;
        for (int n = 0; n < 300; n++) begin
            wr   = 5'($urandom_range(0, 31));
            rst  = ($urandom_range(0, 99) != 0);
            rw   = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 2);
            a1   = (pick == 0) ? prev_wr : (pick == 1) ? wr : 5'($urandom_range(0, 31));
            pick = $urandom_range(0, 2);
            a2   = (pick == 0) ? wr : (pick == 1) ? prev_wr : 5'($urandom_range(0, 31));
            xact("rand", rst, rw, 1'($urandom_range(0, 1)), $urandom, $urandom, wr, a1, a2);
            if (rw) prev_wr = wr;
        end

        // Sweep every register once more to expose any stale entry.
        for (int r = 0; r < 32; r++) begin
            xact("sweep", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(r), 5'(31 - r));
        end

        repeat (3) @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
